rf_dump_engine: RTL

Hardware register-file dump initiator for the pipelined RISC-V core. On a start pulse it sweeps the core's debug read port (`reg_sel` / `reg_data`) across every architectural register. It captures each value and streams it out as index/data beats over a valid/ready interface. This is the on-chip counterpart of the end-of-run register report, so a UART or trace sink can extract final register state without simulator hierarchy access.

---
 rtl/rf_dump_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rf_dump_engine.sv
// rf_dump_engine: sweeps the core debug read port and streams
// every register as an index/data beat over valid/ready.
// Optional macro RF_DUMP_CHECKSUM_EN appends a final XOR beat.
// Ports: clk, rst (async, active-high), start, busy, done,
//   reg_sel/reg_data (debug port), out_valid/out_ready,
//   out_data, out_idx, out_last (stream).
module rf_dump_engine #(
    parameter int NREGS  = 32,
    parameter int SEL_W  = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_idx,
    output logic              out_last
);

`ifdef RF_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SEND, S_SUM, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SEND, S_DONE
    } state_t;
`endif

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREGS - 1);
    localparam logic [1:0]       LAT      = 2'(RD_LAT);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_idx_q, out_idx_d;
    logic                out_last_q, out_last_d;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
`ifdef RF_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
`ifdef RF_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_SEL;
                end
            end
            // Wait RD_LAT+1 cycles for the debug port, then capture.
            S_SEL: begin
                if (cnt_q == LAT) begin
                    out_data_d = reg_data;
                    out_idx_d  = idx_q;
`ifdef RF_DUMP_CHECKSUM_EN
                    out_last_d = 1'b0;
`else
                    out_last_d = (idx_q == LAST_IDX);
`endif
                    state_d    = S_SEND;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_SEND: begin
                if (out_ready) begin
`ifdef RF_DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ out_data_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef RF_DUMP_CHECKSUM_EN
                        // Checksum beat is staged straight into the
                        // output register so SUM needs no extra mux.
                        out_data_d = csum_q ^ out_data_q;
                        out_idx_d  = '0;
                        out_last_d = 1'b1;
                        state_d    = S_SUM;
`else
                        state_d    = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        cnt_d   = '0;
                        state_d = S_SEL;
                    end
                end
            end
`ifdef RF_DUMP_CHECKSUM_EN
            S_SUM: begin
                if (out_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign reg_sel  = idx_q;
    assign out_data = out_data_q;
    assign out_idx  = out_idx_q;
    assign out_last = out_last_q;
`ifdef RF_DUMP_CHECKSUM_EN
    assign out_valid = (state_q == S_SEND) || (state_q == S_SUM);
`else
    assign out_valid = (state_q == S_SEND);
`endif

endmodule
